// File: rtl/fetch_pkg.sv
// Shared constants and payload types for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W      = CNT_W + 1;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Fetch targets are always word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift buffer between imem responses and decode; slot 0 is always the head,
// so the decode-facing outputs come straight from flops and read as zero when empty.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  fetch_entry_t      push_entry,
    input  logic              pop,
    input  logic              flush,
    output logic              head_valid,
    output fetch_entry_t      head_entry,
    output logic [CNT_W-1:0]  count
);

    fetch_entry_t slot0_q, slot1_q;
    logic         val0_q, val1_q;
    logic         pop_ok;

    assign pop_ok = pop && val0_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            val0_q  <= 1'b0;
            val1_q  <= 1'b0;
        end else if (flush) begin
            slot0_q <= '0;
            slot1_q <= '0;
            val0_q  <= 1'b0;
            val1_q  <= 1'b0;
        end else begin
            case ({pop_ok, push})
                2'b11: begin
                    if (val1_q) begin
                        slot0_q <= slot1_q;
                        slot1_q <= push_entry;
                    end else begin
                        slot0_q <= push_entry;
                    end
                end
                2'b10: begin
                    slot0_q <= slot1_q;
                    val0_q  <= val1_q;
                    slot1_q <= '0;
                    val1_q  <= 1'b0;
                end
                2'b01: begin
                    if (!val0_q) begin
                        slot0_q <= push_entry;
                        val0_q  <= 1'b1;
                    end else begin
                        slot1_q <= push_entry;
                        val1_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_valid = val0_q;
    assign head_entry = slot0_q;
    assign count      = CNT_W'(val0_q) + CNT_W'(val1_q);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, one outstanding imem request, 2-entry decode buffer.
// Define FETCH_MISALIGN_CHK_EN to flag misaligned redirect targets and halt fetch until reset.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        misalign
`endif
);

    logic [31:0]      pc_q;
    logic [31:0]      req_pc_q;
    logic             out_q;
    logic             drop_q;
    logic             halt;
    logic             accept;
    logic             pop;
    logic             push;
    logic [CNT_W-1:0] count;
    logic [OCC_W-1:0] occupancy;
    logic [OCC_W-1:0] limit;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    // Sticky until reset: a bad target leaves no sane place to fetch from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign halt     = misalign_q;
    assign misalign = misalign_q;
`else
    assign halt = 1'b0;
`endif

    // Gating includes this cycle's pop so a full-rate stream never bubbles.
    assign occupancy      = OCC_W'(count) + OCC_W'(out_q);
    assign limit          = OCC_W'(FIFO_DEPTH) + OCC_W'(pop);
    assign imem_req_valid = !rst && !halt && (occupancy < limit);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign pop            = dec_valid && dec_ready;

    // A response answers last cycle's accept; any redirect since then kills it.
    assign push       = imem_rsp_valid && out_q && !drop_q && !redirect_valid;
    assign push_entry = '{inst: imem_rsp_data, pc: req_pc_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            out_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            out_q  <= accept;
            drop_q <= redirect_valid;
            if (accept) begin
                req_pc_q <= pc_q;
            end
            if (redirect_valid) begin
                pc_q <= align_word(redirect_pc);
            end else if (accept) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_valid (dec_valid),
        .head_entry (head),
        .count      (count)
    );

    assign dec_inst = head.inst;
    assign dec_pc   = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based reference model checked every cycle,
// plus hand-computed pins on latency, stall, redirect, wrap and reset behaviour.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int LOGN = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign;
    bit          obs_mis [LOGN];
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .misalign       (misalign)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          t = 0;
    bit          nop_mode = 1'b0;
    bit          stray = 1'b0;
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'h0;

    // Reference model state: PC, buffered (pc, inst) pairs, one in-flight request.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] mq_pc [$];
    logic [31:0] mq_inst [$];
    bit          m_infl = 1'b0;
    bit          m_drop = 1'b0;
    logic [31:0] m_infl_pc = 32'h0;
    bit          m_halt = 1'b0;

    bit          obs_dv [LOGN];
    bit          obs_rv [LOGN];
    logic [31:0] obs_dpc [LOGN];
    logic [31:0] obs_inst [LOGN];
    logic [31:0] obs_addr [LOGN];

    logic [15:0] rdy_pat  = 16'b1101_1011_0111_1110;
    logic [11:0] drdy_pat = 12'b1001_1101_0110;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return nop_mode ? NOP : ((a ^ 32'hC0DE_0000) + 32'h0000_0001);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (t=%0d): got 0x%08h, want 0x%08h", name, t, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        #1;
        chk("rst_imem_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_dec_valid", 32'(dec_valid), 32'h0);
        chk("rst_dec_inst", dec_inst, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_imem_req_addr", imem_req_addr, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("rst_misalign", 32'(misalign), 32'h0);
`endif
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_pc = 32'h0;
        mq_pc.delete();
        mq_inst.delete();
        m_infl = 1'b0;
        m_drop = 1'b0;
        m_halt = 1'b0;
        mem_pend = 1'b0;
        stray = 1'b0;
        t = 0;
        for (int i = 0; i < LOGN; i++) begin
            obs_dv[i] = 1'b0; obs_rv[i] = 1'b0;
            obs_dpc[i] = 32'h0; obs_inst[i] = 32'h0; obs_addr[i] = 32'h0;
`ifdef FETCH_MISALIGN_CHK_EN
            obs_mis[i] = 1'b0;
`endif
        end
    endtask

    // One clock cycle: drive at negedge, compare against model, advance model at posedge.
    task automatic step(input bit rdy, input bit drdy, input bit rv, input logic [31:0] rpc);
        bit          exp_dv, exp_rv, pop, nxt_pend;
        logic [31:0] exp_dpc, exp_inst, nxt_addr, tgt;
        imem_req_ready = rdy;
        dec_ready      = drdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_rsp_valid = mem_pend | stray;
        imem_rsp_data  = stray ? 32'hBAD0_0001 : (mem_pend ? data_of(mem_addr) : 32'h0);
        #1;
        exp_dv   = (mq_pc.size() != 0);
        exp_dpc  = exp_dv ? mq_pc[0] : 32'h0;
        exp_inst = exp_dv ? mq_inst[0] : 32'h0;
        pop      = exp_dv && drdy;
        exp_rv   = !m_halt && ((mq_pc.size() + int'(m_infl) - int'(pop)) < int'(FIFO_DEPTH));
        chk("dec_valid", 32'(dec_valid), 32'(exp_dv));
        chk("dec_pc", dec_pc, exp_dpc);
        chk("dec_inst", dec_inst, exp_inst);
        chk("imem_req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("imem_req_addr", imem_req_addr, m_pc);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("misalign", 32'(misalign), 32'(m_halt));
        if (t < LOGN) obs_mis[t] = misalign;
`endif
        if (t < LOGN) begin
            obs_dv[t]   = dec_valid;
            obs_rv[t]   = imem_req_valid;
            obs_dpc[t]  = dec_pc;
            obs_inst[t] = dec_inst;
            obs_addr[t] = imem_req_addr;
        end
        nxt_pend = imem_req_valid && imem_req_ready;
        nxt_addr = imem_req_addr;
        @(posedge clk);
        if (pop) begin
            void'(mq_pc.pop_front());
            void'(mq_inst.pop_front());
        end
        if (m_infl && !m_drop && !rv) begin
            mq_pc.push_back(m_infl_pc);
            mq_inst.push_back(data_of(m_infl_pc));
        end
        if (rv) begin
            mq_pc.delete();
            mq_inst.delete();
`ifdef FETCH_MISALIGN_CHK_EN
            if (rpc[1:0] != 2'b00) m_halt = 1'b1;
`endif
        end
        m_infl    = exp_rv && rdy;
        m_infl_pc = m_pc;
        m_drop    = rv;
        tgt       = rpc;
        tgt[1:0]  = 2'b00;
        if (rv) m_pc = tgt;
        else if (exp_rv && rdy) m_pc = m_pc + 32'd4;
        mem_pend = nxt_pend;
        mem_addr = nxt_addr;
        stray    = 1'b0;
        t++;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_reset(2);

        // Full-rate stream of NOPs from reset.
        nop_mode = 1'b1;
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stream_req_t0", 32'(obs_rv[0]), 32'h1);
        chk("stream_dv_t1", 32'(obs_dv[1]), 32'h0);
        chk("stream_dv_t2", 32'(obs_dv[2]), 32'h1);
        chk("stream_pc_t2", obs_dpc[2], 32'h0);
        chk("stream_pc_t3", obs_dpc[3], 32'h4);
        chk("stream_pc_t4", obs_dpc[4], 32'h8);
        chk("stream_inst_t2", obs_inst[2], 32'h0000_0013);

        // Decode stalled: buffer fills, requests stop, head held.
        do_reset(1);
        nop_mode = 1'b0;
        repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("stall_req_t1", 32'(obs_rv[1]), 32'h1);
        chk("stall_req_t2", 32'(obs_rv[2]), 32'h0);
        chk("stall_req_t4", 32'(obs_rv[4]), 32'h0);
        chk("stall_dv_t4", 32'(obs_dv[4]), 32'h1);
        chk("stall_pc_t4", obs_dpc[4], 32'h0);
        chk("stall_inst_t4", obs_inst[4], 32'hC0DE_0001);

        // Redirect with a full buffer, pop and accept in the same cycle.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_pop_pc_t5", obs_dpc[5], 32'h0);
        chk("redir_req_t6", 32'(obs_rv[6]), 32'h1);
        chk("redir_addr_t6", obs_addr[6], 32'h0000_0100);
        chk("redir_dv_t6", 32'(obs_dv[6]), 32'h0);
        chk("redir_dv_t7", 32'(obs_dv[7]), 32'h0);
        chk("redir_pc_t8", obs_dpc[8], 32'h0000_0100);
        chk("redir_inst_t8", obs_inst[8], 32'hC0DE_0101);
        chk("redir_pc_t9", obs_dpc[9], 32'h0000_0104);

        // Back-to-back redirects: the second target is the first to reach decode.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0180);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("b2b_dv_t13", 32'(obs_dv[13]), 32'h0);
        chk("b2b_addr_t14", obs_addr[14], 32'h0000_0200);
        chk("b2b_dv_t14", 32'(obs_dv[14]), 32'h0);
        chk("b2b_dv_t15", 32'(obs_dv[15]), 32'h0);
        chk("b2b_pc_t16", obs_dpc[16], 32'h0000_0200);

        // PC wraps from the top of the address space.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr_t22", obs_addr[22], 32'hFFFF_FFFC);
        chk("wrap_addr_t23", obs_addr[23], 32'h0000_0000);
        chk("wrap_req_t23", 32'(obs_rv[23]), 32'h1);
        chk("wrap_pc_t24", obs_dpc[24], 32'hFFFF_FFFC);
        chk("wrap_pc_t25", obs_dpc[25], 32'h0000_0000);
        chk("wrap_dv_t25", 32'(obs_dv[25]), 32'h1);

        // Irregular ready patterns with redirects, checked by the model only.
        for (int i = 0; i < 48; i++) begin
            step(rdy_pat[4'(i % 16)], drdy_pat[4'(i % 12)],
                 (i == 9) || (i == 10) || (i == 30) || (i == 31),
                 (i == 9) ? 32'h0000_3000 : (i == 10) ? 32'h0000_4000 : 32'h0000_5000);
        end

        // Reset mid-stream; a stale response in the first cycle after release must be ignored.
        do_reset(1);
        stray = 1'b1;
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rrst_req_t0", 32'(obs_rv[0]), 32'h1);
        chk("rrst_addr_t0", obs_addr[0], 32'h0);
        chk("rrst_dv_t1", 32'(obs_dv[1]), 32'h0);
        chk("rrst_pc_t2", obs_dpc[2], 32'h0);
        chk("rrst_inst_t2", obs_inst[2], 32'hC0DE_0001);

        // Redirect to a target with nonzero low bits.
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_flag_t8", 32'(obs_mis[8]), 32'h0);
        chk("mis_flag_t9", 32'(obs_mis[9]), 32'h1);
        chk("mis_req_t9", 32'(obs_rv[9]), 32'h0);
        chk("mis_req_t13", 32'(obs_rv[13]), 32'h0);
        chk("mis_dv_t10", 32'(obs_dv[10]), 32'h0);
        do_reset(1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mis_clear_req_t0", 32'(obs_rv[0]), 32'h1);
        chk("mis_clear_flag_t0", 32'(obs_mis[0]), 32'h0);
`else
        chk("mis_addr_t9", obs_addr[9], 32'h0000_0100);
        chk("mis_pc_t11", obs_dpc[11], 32'h0000_0100);
        chk("mis_inst_t11", obs_inst[11], 32'hC0DE_0101);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
